// File: rtl/xoodyak_pkg.sv
// -----------------------------------------------------------------------------
// xoodyak_pkg
//   Shared definitions for the Xoodyak sequencer and core interface:
//   default data widths, the core opmode encoding (IDLE..RATCHET plus the
//   continue bit), the sequencer state and phase enums, and helpers that map
//   a phase to its core opmode and to the phase that follows it.
//   No ports (package).
// -----------------------------------------------------------------------------
package xoodyak_pkg;

    localparam int XOOD_TEXT_W = 192;   // text block width
    localparam int XOOD_BLK_W  = 128;   // key / nonce / AD / tag width

    // Low three bits of the core opmode.
    typedef enum logic [2:0] {
        OP_IDLE    = 3'd0,
        OP_INIT    = 3'd1,
        OP_NONCE   = 3'd2,
        OP_ASSOC   = 3'd3,
        OP_CRYPT   = 3'd4,
        OP_DECRYPT = 3'd5,
        OP_SQUEEZE = 3'd6,
        OP_RATCHET = 3'd7
    } opmode_e;

    // Bit 3 of the opmode: continue from the current duplex state.
    localparam logic [3:0] OPMODE_CONT = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } seq_state_e;

    typedef enum logic [2:0] {
        PH_INIT,
        PH_NONCE,
        PH_ASSOC,
        PH_CRYPT,
        PH_SQZ
    } phase_e;

    // Core opmode for a phase. INIT starts a fresh duplex state; every later
    // phase continues from the state left by the previous one.
    function automatic logic [3:0] phase_opmode(input phase_e ph, input logic dec);
        opmode_e op;
        case (ph)
            PH_INIT:  op = OP_INIT;
            PH_NONCE: op = OP_NONCE;
            PH_ASSOC: op = OP_ASSOC;
            PH_CRYPT: op = dec ? OP_DECRYPT : OP_CRYPT;
            PH_SQZ:   op = OP_SQUEEZE;
            default:  op = OP_IDLE;
        endcase
        if (ph == PH_INIT) begin
            return {1'b0, op};
        end
        return OPMODE_CONT | {1'b0, op};
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        case (ph)
            PH_INIT:  return PH_NONCE;
            PH_NONCE: return PH_ASSOC;
            PH_ASSOC: return PH_CRYPT;
            PH_CRYPT: return PH_SQZ;
            default:  return PH_INIT;
        endcase
    endfunction

endpackage

// File: rtl/xood_phase_timer.sv
// -----------------------------------------------------------------------------
// xood_phase_timer
//   Per-phase timeout counter for xoodyak_seq. Cleared while the sequencer
//   issues a phase, counts every cycle spent waiting for the core, and
//   saturates at TIMEOUT_CYC-1, where expired_o is raised.
//   Only instantiated when XOOD_SEQ_TIMEOUT_EN is defined.
//
// Ports
//   eph1        in   clock, rising edge
//   reset       in   synchronous, active-low reset
//   clear_i     in   restart the count (ISSUE cycle)
//   count_en_i  in   count this cycle (WAIT state)
//   expired_o   out  counter has reached TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
module xood_phase_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic eph1,
    input  logic reset,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int               CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge eph1) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/xoodyak_seq.sv
// -----------------------------------------------------------------------------
// xoodyak_seq
//   Phase sequencer for the xoodyak_build core. Accepts one AEAD request,
//   drives the core through INIT -> NONCE -> ASSOC -> CRYPT/DECRYPT -> SQUEEZE
//   with one start/finished handshake per phase, and returns the text output,
//   the tag and (for decryption) the tag verdict. One request in flight.
//
//   Optional feature: define XOOD_SEQ_TIMEOUT_EN to build a per-phase
//   watchdog (xood_phase_timer). A phase that sees no core_finished within
//   TIMEOUT_CYC wait cycles ends the request with resp_error=1. Without the
//   macro, WAIT waits indefinitely and resp_error is always 0.
//
// Ports
//   eph1, reset                         clock / synchronous active-low reset
//   req_valid, req_ready                request handshake (ready only in IDLE)
//   req_dec                             0 = encrypt, 1 = decrypt
//   req_key, req_nonce, req_assodata    BLK_W operands
//   req_text                            TEXT_W plaintext / ciphertext
//   req_tag                             expected tag (decrypt)
//   core_start, core_opmode             phase start pulse and opmode
//   core_key/nonce/assodata/textin      latched operands to the core
//   core_textout, core_finished         core result and phase-done pulse
//   resp_valid, resp_ready              response handshake
//   resp_text, resp_tag                 crypt output / squeeze output
//   resp_auth_ok, resp_error            tag verdict / timeout flag
//   busy                                state != IDLE
// -----------------------------------------------------------------------------
module xoodyak_seq
    import xoodyak_pkg::*;
#(
    parameter int TEXT_W      = XOOD_TEXT_W,
    parameter int BLK_W       = XOOD_BLK_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              eph1,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_dec,
    input  logic [BLK_W-1:0]  req_key,
    input  logic [BLK_W-1:0]  req_nonce,
    input  logic [BLK_W-1:0]  req_assodata,
    input  logic [TEXT_W-1:0] req_text,
    input  logic [BLK_W-1:0]  req_tag,

    output logic              core_start,
    output logic [3:0]        core_opmode,
    output logic [BLK_W-1:0]  core_key,
    output logic [BLK_W-1:0]  core_nonce,
    output logic [BLK_W-1:0]  core_assodata,
    output logic [TEXT_W-1:0] core_textin,
    input  logic [TEXT_W-1:0] core_textout,
    input  logic              core_finished,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [TEXT_W-1:0] resp_text,
    output logic [BLK_W-1:0]  resp_tag,
    output logic              resp_auth_ok,
    output logic              resp_error,

    output logic              busy
);

    // The tag is taken from the low bits of the core text bus, and the
    // watchdog needs at least a two-cycle window to be meaningful.
    if (BLK_W > TEXT_W || TIMEOUT_CYC < 2) begin : g_param_check
        $error("xoodyak_seq: need BLK_W <= TEXT_W and TIMEOUT_CYC >= 2");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    seq_state_e        state_q,  state_d;
    phase_e            phase_q,  phase_d;
    logic              dec_q,    dec_d;
    logic [BLK_W-1:0]  key_q,    key_d;
    logic [BLK_W-1:0]  nonce_q,  nonce_d;
    logic [BLK_W-1:0]  ad_q,     ad_d;
    logic [TEXT_W-1:0] text_q,   text_d;
    logic [BLK_W-1:0]  etag_q,   etag_d;     // expected tag from the request
    logic [TEXT_W-1:0] rtext_q,  rtext_d;
    logic [BLK_W-1:0]  rtag_q,   rtag_d;
    logic              auth_q,   auth_d;
    logic              err_q,    err_d;

    logic              accept;
    logic              timeout_hit;

    assign accept = req_valid && req_ready;

    // ------------------------------------------------------------------
    // Optional per-phase watchdog
    // ------------------------------------------------------------------
`ifdef XOOD_SEQ_TIMEOUT_EN
    logic timer_expired;

    xood_phase_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_phase_timer (
        .eph1       (eph1),
        .reset      (reset),
        .clear_i    (state_q == ST_ISSUE),
        .count_en_i (state_q == ST_WAIT),
        .expired_o  (timer_expired)
    );

    assign timeout_hit = timer_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every next-state value is defaulted to its current value
        // before the case, so no path leaves one unassigned (no latches).
        state_d = state_q;
        phase_d = phase_q;
        dec_d   = dec_q;
        key_d   = key_q;
        nonce_d = nonce_q;
        ad_d    = ad_q;
        text_d  = text_q;
        etag_d  = etag_q;
        rtext_d = rtext_q;
        rtag_d  = rtag_q;
        auth_d  = auth_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dec_d   = req_dec;
                    key_d   = req_key;
                    nonce_d = req_nonce;
                    ad_d    = req_assodata;
                    text_d  = req_text;
                    etag_d  = req_tag;
                    rtext_d = '0;
                    rtag_d  = '0;
                    auth_d  = 1'b0;
                    err_d   = 1'b0;
                    phase_d = PH_INIT;
                    state_d = ST_ISSUE;
                end
            end

            // Single start cycle; core_finished is deliberately not looked
            // at here so a stale pulse cannot skip a phase.
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // A finish on the expiry cycle takes priority over the timeout.
                if (core_finished) begin
                    if (phase_q == PH_SQZ) begin
                        rtag_d  = core_textout[BLK_W-1:0];
                        auth_d  = dec_q ? (core_textout[BLK_W-1:0] == etag_q) : 1'b1;
                        err_d   = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        if (phase_q == PH_CRYPT) begin
                            rtext_d = core_textout;
                        end
                        phase_d = next_phase(phase_q);
                        state_d = ST_ISSUE;
                    end
                end else if (timeout_hit) begin
                    rtext_d = '0;
                    rtag_d  = '0;
                    auth_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge eph1) begin
        // NOTE: the wide operand and result registers are reset as well,
        // since every output must read 0 while and right after reset.
        if (!reset) begin
            state_q <= ST_IDLE;
            phase_q <= PH_INIT;
            dec_q   <= 1'b0;
            key_q   <= '0;
            nonce_q <= '0;
            ad_q    <= '0;
            text_q  <= '0;
            etag_q  <= '0;
            rtext_q <= '0;
            rtag_q  <= '0;
            auth_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of everything it depends on.
            state_q <= state_d;
            phase_q <= phase_d;
            dec_q   <= dec_d;
            key_q   <= key_d;
            nonce_q <= nonce_d;
            ad_q    <= ad_d;
            text_q  <= text_d;
            etag_q  <= etag_d;
            rtext_q <= rtext_d;
            rtag_q  <= rtag_d;
            auth_q  <= auth_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign core_start    = (state_q == ST_ISSUE);
    assign core_opmode   = (state_q == ST_ISSUE || state_q == ST_WAIT)
                           ? phase_opmode(phase_q, dec_q) : 4'h0;

    assign core_key      = key_q;
    assign core_nonce    = nonce_q;
    assign core_assodata = ad_q;
    assign core_textin   = text_q;

    assign resp_valid    = (state_q == ST_RESP);
    assign resp_text     = rtext_q;
    assign resp_tag      = rtag_q;
    assign resp_auth_ok  = auth_q;
    assign resp_error    = err_q;

endmodule

// File: tb/tb_xoodyak_seq.sv
// -----------------------------------------------------------------------------
// tb_xoodyak_seq
//   Directed bench for xoodyak_seq with a stub core that raises finished three
//   cycles after each start. Covers reset values, encrypt / decrypt flows,
//   tag verdicts, response back-pressure, mid-operation reset, a stray
//   finished pulse in an ISSUE cycle, and the NONCE stall behaviour with and
//   without XOOD_SEQ_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_xoodyak_seq;

    localparam int TEXT_W      = 192;
    localparam int BLK_W       = 128;
    localparam int TIMEOUT_CYC = 16;

    localparam logic [127:0] KEY     = 128'h38393a3b3c3d3e3f3031323334353637;
    localparam logic [127:0] NONCE   = 128'h494a4b4c4d4e4f504142434445464748;
    localparam logic [127:0] AD      = 128'h696a6b6c6d6e6f706162636465666768;
    localparam logic [191:0] TEXT    = 192'h4d4e4f50_51525354_55565758_41424344_45464748_494a4b4c;

    // Stub core results.
    localparam logic [191:0] CRYPT_OUT = 192'hc0c1c2c3_c4c5c6c7_c8c9cacb_cccdcecf_d0d1d2d3_d4d5a5a5;
    localparam logic [191:0] SQZ_OUT   = 192'h5a5a5a5a_f0f1f2f3_f4f5f6f7_f8f9fafb_fcfdfeff_e0e11234;
    localparam logic [191:0] OTHER_OUT = 192'hdeadbeef_deadbeef_deadbeef_deadbeef_deadbeef_deadbeef;
    // Low 128 bits of SQZ_OUT, written out by hand.
    localparam logic [127:0] EXP_TAG   = 128'hf4f5f6f7_f8f9fafb_fcfdfeff_e0e11234;

    logic              eph1 = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_dec;
    logic [127:0]      req_key;
    logic [127:0]      req_nonce;
    logic [127:0]      req_assodata;
    logic [191:0]      req_text;
    logic [127:0]      req_tag;
    logic              core_start;
    logic [3:0]        core_opmode;
    logic [127:0]      core_key;
    logic [127:0]      core_nonce;
    logic [127:0]      core_assodata;
    logic [191:0]      core_textin;
    logic [191:0]      core_textout;
    logic              core_finished;
    logic              resp_valid;
    logic              resp_ready;
    logic [191:0]      resp_text;
    logic [127:0]      resp_tag;
    logic              resp_auth_ok;
    logic              resp_error;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 eph1 = ~eph1;

    int cyc = 0;
    always @(posedge eph1) cyc <= cyc + 1;

    xoodyak_seq #(
        .TEXT_W      (TEXT_W),
        .BLK_W       (BLK_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .eph1          (eph1),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dec       (req_dec),
        .req_key       (req_key),
        .req_nonce     (req_nonce),
        .req_assodata  (req_assodata),
        .req_text      (req_text),
        .req_tag       (req_tag),
        .core_start    (core_start),
        .core_opmode   (core_opmode),
        .core_key      (core_key),
        .core_nonce    (core_nonce),
        .core_assodata (core_assodata),
        .core_textin   (core_textin),
        .core_textout  (core_textout),
        .core_finished (core_finished),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_text     (resp_text),
        .resp_tag      (resp_tag),
        .resp_auth_ok  (resp_auth_ok),
        .resp_error    (resp_error),
        .busy          (busy)
    );

    // ------------------------------------------------------------------
    // Stub core: finished three cycles after start, opmode log
    // ------------------------------------------------------------------
    logic       stall_nonce;
    logic       spur;
    logic       stub_fin  = 1'b0;
    int         stub_cnt  = 0;
    logic [3:0] stub_mode = 4'h0;
    logic [3:0] log_op [256];
    int         log_n = 0;

    always @(posedge eph1) begin
        stub_fin <= 1'b0;
        if (!reset) begin
            stub_cnt <= 0;
        end else if (core_start) begin
            stub_cnt         <= 1;
            stub_mode        <= core_opmode;
            log_op[log_n]    <= core_opmode;
            log_n            <= log_n + 1;
        end else if (stub_cnt == 2) begin
            stub_cnt <= 0;
            if (!(stall_nonce && stub_mode == 4'hA)) stub_fin <= 1'b1;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt + 1;
        end
    end

    always_comb begin
        case (stub_mode[2:0])
            3'd4, 3'd5: core_textout = CRYPT_OUT;
            3'd6:       core_textout = SQZ_OUT;
            default:    core_textout = OTHER_OUT;
        endcase
    end

    assign core_finished = stub_fin | spur;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one request; returns the acceptance cycle and the log index of
    // its first phase. Request operands are scrambled after acceptance so
    // the core_* outputs must come from the latched copies.
    task automatic offer(input logic dec, input logic [127:0] tag, output int n0, output int base);
        @(negedge eph1);
        req_dec      = dec;
        req_tag      = tag;
        req_key      = KEY;
        req_nonce    = NONCE;
        req_assodata = AD;
        req_text     = TEXT;
        req_valid    = 1'b1;
        check("req_ready_offer", req_ready, 1'b1);
        n0   = cyc;
        base = log_n;
        @(negedge eph1);
        req_valid    = 1'b0;
        req_key      = ~KEY;
        req_nonce    = ~NONCE;
        req_assodata = ~AD;
        req_text     = ~TEXT;
        req_tag      = ~tag;
    endtask

    // Wait (bounded) for resp_valid; lat = cycles since acceptance, -1 if none.
    task automatic wait_resp(input int n0, output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (resp_valid) begin
                lat = cyc - n0;
                break;
            end
            @(negedge eph1);
        end
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(negedge eph1);
        resp_ready = 1'b0;
        check("idle_after_resp", {resp_valid, req_ready, busy}, 3'b010);
    endtask

    task automatic check_ops(input int base, input logic [3:0] crypt_op);
        check("op_init",  log_op[base + 0], 4'h1);
        check("op_nonce", log_op[base + 1], 4'hA);
        check("op_assoc", log_op[base + 2], 4'hB);
        check("op_crypt", log_op[base + 3], crypt_op);
        check("op_sqz",   log_op[base + 4], 4'hE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int n0;
        int base;
        int lat;

        reset        = 1'b0;
        req_valid    = 1'b0;
        req_dec      = 1'b0;
        req_key      = '0;
        req_nonce    = '0;
        req_assodata = '0;
        req_text     = '0;
        req_tag      = '0;
        resp_ready   = 1'b0;
        spur         = 1'b0;
        stall_nonce  = 1'b0;

        // Reset values.
        repeat (3) @(negedge eph1);
        check("rst_core_start", core_start, 1'b0);
        check("rst_opmode",     core_opmode, 4'h0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_busy",       busy, 1'b0);
        check("rst_flags",      {resp_error, resp_auth_ok}, 2'b00);
        check("rst_resp_text",  resp_text, 192'h0);
        check("rst_resp_tag",   resp_tag, 128'h0);
        check("rst_core_key",   core_key, 128'h0);
        check("rst_core_text",  core_textin, 192'h0);
        reset = 1'b1;
        @(negedge eph1);
        check("rst_req_ready",  req_ready, 1'b1);

        // 1) Encrypt, stray finished in the first ISSUE cycle, 10-cycle hold.
        offer(1'b0, 128'h0, n0, base);
        check("issue_start", {core_start, core_opmode}, 5'b1_0001);
        spur = 1'b1;
        @(negedge eph1);
        spur = 1'b0;
        check("spur_no_advance", core_opmode, 4'h1);
        wait_resp(n0, lat);
        check("enc_latency", lat, 21);
        check_ops(base, 4'hC);
        check("enc_auth",  resp_auth_ok, 1'b1);
        check("enc_err",   resp_error, 1'b0);
        check("enc_text",  resp_text, CRYPT_OUT);
        check("enc_tag",   resp_tag, EXP_TAG);
        check("enc_key",   core_key, KEY);
        check("enc_nonce", core_nonce, NONCE);
        check("enc_ad",    core_assodata, AD);
        check("enc_textin", core_textin, TEXT);
        for (int i = 0; i < 10; i++) begin
            @(negedge eph1);
            check("hold_valid_ready", {resp_valid, req_ready}, 2'b10);
            check("hold_text", resp_text, CRYPT_OUT);
            check("hold_tag",  resp_tag, EXP_TAG);
        end
        release_resp();

        // 2) Decrypt with the correct tag.
        offer(1'b1, EXP_TAG, n0, base);
        wait_resp(n0, lat);
        check("dec_ok_latency", lat, 21);
        check_ops(base, 4'hD);
        check("dec_ok_auth", resp_auth_ok, 1'b1);
        check("dec_ok_tag",  resp_tag, EXP_TAG);
        release_resp();

        // 3) Decrypt with tag bit 0 flipped.
        offer(1'b1, EXP_TAG ^ 128'h1, n0, base);
        wait_resp(n0, lat);
        check("dec_bad_latency", lat, 21);
        check("dec_bad_auth", resp_auth_ok, 1'b0);
        check("dec_bad_text", resp_text, CRYPT_OUT);
        release_resp();

        // 4) Reset during the ASSOC wait, then a clean request.
        offer(1'b0, 128'h0, n0, base);
        for (int i = 0; i < 50 && log_n != base + 3; i++) @(negedge eph1);
        check("assoc_reached", log_n - base, 3);
        check("assoc_wait_op", {core_start, core_opmode}, 5'b0_1011);
        reset = 1'b0;
        @(negedge eph1);
        check("abort_busy",   busy, 1'b0);
        check("abort_opmode", {core_start, core_opmode}, 5'b0_0000);
        check("abort_resp",   resp_valid, 1'b0);
        reset = 1'b1;
        offer(1'b0, 128'h0, n0, base);
        wait_resp(n0, lat);
        check("post_rst_latency", lat, 21);
        check_ops(base, 4'hC);
        check("post_rst_tag", resp_tag, EXP_TAG);
        release_resp();

        // 5) Core never finishes NONCE.
        stall_nonce = 1'b1;
`ifdef XOOD_SEQ_TIMEOUT_EN
        // NONCE ISSUE at N+5, 16 WAIT cycles, RESP at N+22.
        offer(1'b0, 128'h0, n0, base);
        wait_resp(n0, lat);
        check("tmo_latency", lat, 22);
        check("tmo_flags",   {resp_error, resp_auth_ok}, 2'b10);
        check("tmo_text",    resp_text, 192'h0);
        check("tmo_tag",     resp_tag, 128'h0);
        release_resp();
        stall_nonce = 1'b0;
`else
        offer(1'b0, 128'h0, n0, base);
        repeat (40) @(negedge eph1);
        check("stall_no_resp", {resp_valid, resp_error, busy}, 3'b001);
        check("stall_opmode",  core_opmode, 4'hA);
        reset = 1'b0;
        @(negedge eph1);
        reset = 1'b1;
        stall_nonce = 1'b0;
        check("stall_recovered", {busy, req_ready}, 2'b01);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
